// File: rtl/button_event_ctrl_pkg.sv
// Shared event codes, per-button FSM states and helpers for button_event_ctrl.
package button_event_ctrl_pkg;

  localparam int BTN_IDX_W = 3;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic      vld;
    evt_kind_e kind;
  } slot_t;

  // Hold counters stop at all-ones instead of wrapping back to a short hold.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/button_event_ctrl_rr_arbiter.sv
// Round-robin selector over occupied event slots; search starts after the last grant.
module rr_arbiter
  import button_event_ctrl_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [BTN_IDX_W-1:0] gnt_idx,
  output logic                 gnt_any
);

  logic [BTN_IDX_W-1:0] last_q;

  // Two passes: indices above the last grant first, then wrap to the rest.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (!gnt_any && req[j] && j > int'(last_q)) begin
        gnt_any = 1'b1;
        gnt_idx = BTN_IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!gnt_any && req[j] && j <= int'(last_q)) begin
        gnt_any = 1'b1;
        gnt_idx = BTN_IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     last_q <= '0;
    else if (advance && gnt_any) last_q <= gnt_idx;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Per-button PRESS/RELEASE/LONG/REPEAT event generator with one-deep slots,
// round-robin arbitration and a registered valid/ready event output.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int NUM_BTN   = 5,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_lvl,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2:0]         evt_btn,
  output logic [1:0]         evt_kind,
  output logic               evt_drop,
  input  logic               drop_clr
);

  localparam int DIV = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;

  logic [31:0] presc_q;
  logic        ms_tick;

  assign ms_tick = (presc_q == 32'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          presc_q <= '0;
    else if (ms_tick) presc_q <= '0;
    else              presc_q <= presc_q + 32'd1;
  end

  logic [NUM_BTN-1:0] btn_q, rise, fall;

  assign rise = btn_lvl & ~btn_q;
  assign fall = ~btn_lvl & btn_q;

  btn_state_e         st_q    [NUM_BTN];
  btn_state_e         st_d    [NUM_BTN];
  logic [15:0]        cnt_q   [NUM_BTN];
  logic [15:0]        cnt_d   [NUM_BTN];
  logic [15:0]        cnt_inc [NUM_BTN];
  logic [NUM_BTN-1:0] new_vld;
  evt_kind_e          new_kind[NUM_BTN];

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_inc[i]  = sat_inc(cnt_q[i], ms_tick);
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_inc[i];
      new_vld[i]  = 1'b0;
      new_kind[i] = EVT_PRESS;
      case (st_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (rise[i]) begin
            st_d[i]    = ST_HOLD;
            new_vld[i] = 1'b1;
          end
        end
        ST_HOLD: begin
          if (fall[i]) begin
            st_d[i]     = ST_IDLE;
            cnt_d[i]    = '0;
            new_vld[i]  = 1'b1;
            new_kind[i] = EVT_RELEASE;
          end else if (cnt_inc[i] >= 16'(LONG_MS)) begin
            st_d[i]     = ST_RPT;
            cnt_d[i]    = '0;
            new_vld[i]  = 1'b1;
            new_kind[i] = EVT_LONG;
          end
        end
        ST_RPT: begin
          if (fall[i]) begin
            st_d[i]     = ST_IDLE;
            cnt_d[i]    = '0;
            new_vld[i]  = 1'b1;
            new_kind[i] = EVT_RELEASE;
          end else if (cnt_inc[i] >= 16'(REPEAT_MS)) begin
            cnt_d[i]    = '0;
            new_vld[i]  = 1'b1;
            new_kind[i] = EVT_REPEAT;
          end
        end
        default: begin
          st_d[i]  = ST_IDLE;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      btn_q <= btn_lvl;
      for (int i = 0; i < NUM_BTN; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  slot_t                slot_q[NUM_BTN];
  logic [NUM_BTN-1:0]   slot_vld, gnt_vec;
  logic [BTN_IDX_W-1:0] gnt_idx;
  logic                 gnt_any, load, drop_set;
  evt_kind_e            g_kind;

  // Output register takes a new grant when empty or when its event is leaving.
  assign load = gnt_any && (!evt_valid || evt_ready);

  rr_arbiter #(.N(NUM_BTN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (slot_vld),
    .advance (load),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    slot_vld = '0;
    gnt_vec  = '0;
    g_kind   = EVT_PRESS;
    for (int i = 0; i < NUM_BTN; i++) begin
      slot_vld[i] = slot_q[i].vld;
      if (gnt_idx == BTN_IDX_W'(i)) begin
        gnt_vec[i] = load;
        g_kind     = slot_q[i].kind;
      end
    end
  end

  // A slot being granted this cycle can be refilled without counting as a drop.
  assign drop_set = |(new_vld & slot_vld & ~gnt_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) slot_q[i] <= '{vld: 1'b0, kind: EVT_PRESS};
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (new_vld[i])      slot_q[i] <= '{vld: 1'b1, kind: new_kind[i]};
        else if (gnt_vec[i]) slot_q[i].vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_kind  <= '0;
    end else if (load) begin
      evt_valid <= 1'b1;
      evt_btn   <= gnt_idx;
      evt_kind  <= g_kind;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           evt_drop <= 1'b0;
    else if (drop_set) evt_drop <= 1'b1;
    else if (drop_clr) evt_drop <= 1'b0;
  end

endmodule
